wb_arbiter2: RTL and testbench

Two-master Wishbone classic arbiter. It shares one Wishbone slave port, typically the RAM, between two requesters, e.g. the J1 data bus and a DMA/debug master. Grants are round-robin and locked for the whole `cyc` burst. A watchdog terminates any slave cycle that is not acknowledged in time. It sits between the masters and `wb_intercon`.

---
 rtl/wb_arbiter2.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter2.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// +--------------------------------------------------------------------------+
// | wb_arbiter2 : two-master Wishbone classic arbiter, round-robin, cyc-lock |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_arbiter2 #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam logic [7:0] TMO  = 8'(TIMEOUT);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wdog, wdog_nxt;
  logic       own_cyc, own_stb, timeout;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      GNT0: begin own_cyc = m0_cyc_i; own_stb = m0_stb_i; end
      GNT1: begin own_cyc = m1_cyc_i; own_stb = m1_stb_i; end
      default: ;
    endcase
  end

  // A same-cycle ack beats the watchdog.
  assign timeout = own_cyc & own_stb & ~s_ack_i & (wdog == TMO);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_nxt  = 1'b0;
          state_nxt = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_nxt  = 1'b1;
          state_nxt = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (state == IDLE || state_nxt != state || s_ack_i || timeout)
      wdog_nxt = 8'd0;
    else if (own_stb)
      wdog_nxt = wdog + 8'd1;
    else
      wdog_nxt = wdog;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= 8'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout;
      end
      default: ;
    endcase
  end

  assign s_cyc_o = own_cyc & ~timeout;
  assign s_stb_o = own_stb & ~timeout;
  assign gnt_o   = {state == GNT1, state == GNT0};

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter2 : directed and randomized bench for wb_arbiter2           |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc[2], stb[2], we[2];
  logic [15:0] adr[2], wdat[2];
  logic [1:0]  sel[2];
  logic        n_cyc[2], n_stb[2], n_we[2];
  logic [15:0] n_adr[2], n_wdat[2];
  logic [1:0]  n_sel[2];
  logic [15:0] mdat[2];
  logic        mack[2], merr[2];
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [15:0] s_adr, s_dat, s_rdat;
  logic [1:0]  s_sel, gnt;

  wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_dat_o(mdat[0]), .m0_ack_o(mack[0]),
    .m0_err_o(merr[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_dat_o(mdat[1]), .m1_ack_o(mack[1]),
    .m1_err_o(merr[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  // Reference model: who owns the slave, who owned it last, unanswered strobe cycles.
  int  owner;
  bit  last;
  int  waits;
  logic [1:0]  e_gnt, e_sel;
  logic        e_scyc, e_sstb, e_swe;
  logic [15:0] e_sadr, e_sdat;
  logic        e_ack[2], e_err[2];
  logic [15:0] e_dat[2];

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  int left[2];

  function automatic bit expired();
    return owner >= 0 && cyc[owner] && stb[owner] && waits == TO && !s_ack;
  endfunction

  function automatic void model_reset();
    owner = -1;
    last  = 1'b1;
    waits = 0;
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      waits = 0;
      if (cyc[0] && cyc[1]) owner = last ? 0 : 1;
      else if (cyc[0])      owner = 0;
      else if (cyc[1])      owner = 1;
    end else if (!cyc[owner]) begin
      last  = (owner == 1);
      owner = cyc[1-owner] ? 1 - owner : -1;
      waits = 0;
    end else if (s_ack || expired()) begin
      waits = 0;
    end else if (stb[owner]) begin
      waits = waits + 1;
    end
  endfunction

  function automatic void eval();
    bit t;
    t      = expired();
    e_gnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_scyc = (owner >= 0) ? (cyc[owner] && !t) : 1'b0;
    e_sstb = (owner >= 0) ? (stb[owner] && !t) : 1'b0;
    e_swe  = (owner >= 0) ? we[owner]   : 1'b0;
    e_sadr = (owner >= 0) ? adr[owner]  : 16'h0;
    e_sdat = (owner >= 0) ? wdat[owner] : 16'h0;
    e_sel  = (owner >= 0) ? sel[owner]  : 2'b00;
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = (owner == m) ? s_ack : 1'b0;
      e_err[m] = (owner == m) && t;
      e_dat[m] = (owner == m) ? s_rdat : 16'h0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt_o", 32'(gnt), 32'(e_gnt));
      check("s_cyc_o", 32'(s_cyc), 32'(e_scyc));
      check("s_stb_o", 32'(s_stb), 32'(e_sstb));
      check("s_we_o", 32'(s_we), 32'(e_swe));
      check("s_adr_o", 32'(s_adr), 32'(e_sadr));
      check("s_dat_o", 32'(s_dat), 32'(e_sdat));
      check("s_sel_o", 32'(s_sel), 32'(e_sel));
      for (int m = 0; m < 2; m++) begin
        check($sformatf("m%0d_ack_o", m), 32'(mack[m]), 32'(e_ack[m]));
        check($sformatf("m%0d_err_o", m), 32'(merr[m]), 32'(e_err[m]));
        check($sformatf("m%0d_dat_o", m), 32'(mdat[m]), 32'(e_dat[m]));
      end
    end
  end

  task automatic apply();
    cyc = n_cyc; stb = n_stb; we = n_we;
    adr = n_adr; wdat = n_wdat; sel = n_sel;
  endtask

  // One clock: model edge, new master inputs, slave response (0 none, 1 ack, 2 random).
  task automatic cycle(input int mode, input logic [15:0] d);
    bit own_stb;
    @(posedge clk);
    model_step();
    #1;
    apply();
    s_ack = 1'b0;
    #1;
    own_stb = owner >= 0 && cyc[owner] && stb[owner];
    case (mode)
      0:       s_ack = 1'b0;
      1:       s_ack = own_stb;
      default: s_ack = own_stb && ($urandom % 3 == 0);
    endcase
    s_rdat = d;
    #1;
    eval();
  endtask

  task automatic stage(input int m, input logic c, input logic s, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    n_cyc[m] = c; n_stb[m] = s; n_we[m] = w;
    n_adr[m] = a; n_wdat[m] = d; n_sel[m] = 2'b11;
  endtask

  task automatic stage_rand(input int m);
    n_stb[m]  = 1'b1;
    n_we[m]   = 1'($urandom);
    n_adr[m]  = 16'($urandom);
    n_wdat[m] = 16'($urandom);
    n_sel[m]  = 2'($urandom);
  endtask

  task automatic master_update(input int m);
    if (n_cyc[m] && n_stb[m] && (e_ack[m] || e_err[m])) begin
      left[m]--;
      if (left[m] <= 0) begin
        n_cyc[m] = 1'b0; n_stb[m] = 1'b0;
      end else if ($urandom % 4 == 0) begin
        n_stb[m] = 1'b0;
      end else begin
        stage_rand(m);
      end
    end else if (n_cyc[m] && !n_stb[m]) begin
      if ($urandom % 2 == 0) stage_rand(m);
    end else if (n_cyc[m] && e_gnt[m] == 1'b0 && $urandom % 32 == 0) begin
      n_cyc[m] = 1'b0; n_stb[m] = 1'b0;
    end else if (!n_cyc[m] && $urandom % 3 == 0) begin
      n_cyc[m] = 1'b1;
      left[m]  = 1 + int'($urandom % 4);
      stage_rand(m);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    s_ack  = 1'b0;
    s_rdat = 16'h0;
    stage(0, 0, 0, 0, 16'h0, 16'h0);
    stage(1, 0, 0, 0, 16'h0, 16'h0);
    apply();
    model_reset();
    eval();
    cmp_en = 1'b1;

    cycle(0, 16'h0);
    cycle(0, 16'h0);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_scyc", 32'(s_cyc), 32'h0);
    rst_n = 1'b1;

    // Tie from reset: master 0 first, read of 0x0100 acked two cycles after stb.
    stage(0, 1, 1, 0, 16'h0100, 16'h0);
    stage(1, 1, 1, 1, 16'h0200, 16'h1234);
    cycle(0, 16'h0);
    check("req_seen_gnt", 32'(gnt), 32'h0);
    cycle(0, 16'h0);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_adr", 32'(s_adr), 32'h0100);
    cycle(0, 16'h0);
    check("m0_wait_ack", 32'(mack[0]), 32'h0);
    cycle(1, 16'hBEEF);
    check("m0_ack", 32'(mack[0]), 32'h1);
    check("m0_rdat", 32'(mdat[0]), 32'hBEEF);
    check("m1_no_ack", 32'(mack[1]), 32'h0);
    stage(0, 0, 0, 0, 16'h0, 16'h0);
    cycle(0, 16'h0);
    check("drop_gnt", 32'(gnt), 32'h1);
    cycle(0, 16'h0);
    check("handoff_gnt", 32'(gnt), 32'h2);
    check("handoff_dat", 32'(s_dat), 32'h1234);
    cycle(1, 16'h0);
    check("m1_ack", 32'(mack[1]), 32'h1);
    stage(1, 0, 0, 0, 16'h0, 16'h0);
    cycle(0, 16'h0);
    cycle(0, 16'h0);
    check("idle_gnt", 32'(gnt), 32'h0);

    // Watchdog: error on the fifth unanswered strobe cycle, then ack beats it.
    stage(0, 1, 1, 0, 16'h0300, 16'h0);
    cycle(0, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 16'h0);
      check($sformatf("pre_to_err%0d", i), 32'(merr[0]), 32'h0);
    end
    cycle(0, 16'h0);
    check("to_err", 32'(merr[0]), 32'h1);
    check("to_stb", 32'(s_stb), 32'h0);
    check("to_gnt", 32'(gnt), 32'h1);
    cycle(0, 16'h0);
    check("post_to_err", 32'(merr[0]), 32'h0);
    check("post_to_stb", 32'(s_stb), 32'h1);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0);
    cycle(1, 16'h5A5A);
    check("to_ack_wins_ack", 32'(mack[0]), 32'h1);
    check("to_ack_wins_err", 32'(merr[0]), 32'h0);
    check("to_ack_wins_stb", 32'(s_stb), 32'h1);
    stage(0, 0, 0, 0, 16'h0, 16'h0);
    cycle(0, 16'h0);
    cycle(0, 16'h0);

    // Reset in the middle of a master 1 write.
    stage(1, 1, 1, 1, 16'h0400, 16'hCAFE);
    cycle(0, 16'h0);
    cycle(0, 16'h0);
    check("m1_write_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    model_reset();
    eval();
    check("async_rst_scyc", 32'(s_cyc), 32'h0);
    check("async_rst_gnt", 32'(gnt), 32'h0);
    stage(0, 1, 1, 0, 16'h0500, 16'h0);
    cycle(0, 16'h0);
    cycle(0, 16'h0);
    rst_n = 1'b1;
    cycle(0, 16'h0);
    check("post_rst_tie", 32'(gnt), 32'h1);

    // Lock: three acked strobes by master 0 while master 1 waits.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'(i));
      check($sformatf("lock_gnt%0d", i), 32'(gnt), 32'h1);
      check($sformatf("lock_ack%0d", i), 32'(mack[0]), 32'h1);
    end
    stage(0, 0, 0, 0, 16'h0, 16'h0);
    cycle(0, 16'h0);
    cycle(0, 16'h0);
    check("lock_release", 32'(gnt), 32'h2);

    left[0] = 0;
    left[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      master_update(0);
      master_update(1);
      cycle(((i / 50) % 4 == 3) ? 0 : 2, 16'($urandom));
    end

    @(posedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
